// File: rtl/instruction_sequencer.sv
// PC owner and fetch/issue controller: skips NOP words, issues each instruction over valid/ready, waits for done.
// Optional macro SEQ_SINGLE_STEP_EN adds a `step` input for one-instruction passes out of IDLE.
module instruction_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    input  logic                   run,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   done,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   halted,
    output logic [15:0]            retired_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC
    } seqState_t;

    seqState_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [15:0]            retiredCount_q, retiredCount_d;
    logic                   instrValid_q, instrValid_d;
    logic                   halted_q, halted_d;
    logic                   stepActive;
    logic                   stepStart;

`ifdef SEQ_SINGLE_STEP_EN
    logic stepMode_q, stepMode_d;

    assign stepActive = stepMode_q;
    assign stepStart  = step;
`else
    assign stepActive = 1'b0;
    assign stepStart  = 1'b0;
`endif

    // Next-state logic; a single-step pass keeps going with run low and always ends in IDLE.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        retiredCount_d = retiredCount_q;
`ifdef SEQ_SINGLE_STEP_EN
        stepMode_d     = stepMode_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end else if (stepStart) begin
                    state_d = FETCH;
`ifdef SEQ_SINGLE_STEP_EN
                    stepMode_d = 1'b1;
`endif
                end
            end
            FETCH: begin
                if (!run && !stepActive) begin
                    state_d = IDLE;
                end else if (imem_instruction == '0) begin
                    pc_d = pc_q + 1'b1;
                end else begin
                    instr_d = imem_instruction;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (done) begin
                    pc_d           = branch_taken ? branch_target : pc_q + 1'b1;
                    retiredCount_d = retiredCount_q + 16'd1;
                    state_d        = (run && !stepActive) ? FETCH : IDLE;
`ifdef SEQ_SINGLE_STEP_EN
                    stepMode_d     = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        instrValid_d = (state_d == ISSUE);
        halted_d     = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            retiredCount_q <= '0;
            instrValid_q   <= 1'b0;
            halted_q       <= 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
            stepMode_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            retiredCount_q <= retiredCount_d;
            instrValid_q   <= instrValid_d;
            halted_q       <= halted_d;
`ifdef SEQ_SINGLE_STEP_EN
            stepMode_q     <= stepMode_d;
`endif
        end
    end

    assign imem_address  = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = instrValid_q;
    assign halted        = halted_q;
    assign retired_count = retiredCount_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: the memory image and a next-non-NOP scan predict every issue.
module tb_instruction_sequencer;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic [7:0]  imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] retired_count;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif

    logic [31:0] mem [256];
    int compared;
    int mismatched;
    int expPc;
    int expCount;
    bit modelIdle;

    instruction_sequencer dut (
        .clock(clock),
        .reset_n(reset_n),
`ifdef SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .run(run),
        .imem_address(imem_address),
        .imem_instruction(imem_instruction),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .done(done),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .halted(halted),
        .retired_count(retired_count)
    );

    assign imem_instruction = mem[imem_address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int nextIssuePc(input int from);
        for (int i = 0; i < 256; i++) begin
            if (mem[(from + i) % 256] != 32'd0) return (from + i) % 256;
        end
        return -1;
    endfunction

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        run = 1'b0;
        instr_ready = 1'b0;
        done = 1'b0;
        branch_taken = 1'b0;
        branch_target = 8'd0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        expPc = 0;
        expCount = 0;
        modelIdle = 1'b1;
    endtask

    // One instruction from fetch to retire, with checks on issue address, latency, stability and retire.
    task automatic issueOne(input bit taken, input logic [7:0] target, input int readyDelay,
                            input int doneDelay, input bit stopRun);
        int expIssue;
        int expWait;
        int w;
        logic [31:0] held;
        expIssue = nextIssuePc(expPc);
        expWait = ((expIssue - expPc + 256) % 256) + (modelIdle ? 2 : 1);
        modelIdle = 1'b0;
        w = 0;
        do begin
            tick();
            w++;
        end while (!instr_valid && w < 600);
        compared++;
        if (instr_valid !== 1'b1) begin
            $display("[TB] FAIL issue_timeout: instr_valid=%b after %0d cycles, required 1", instr_valid, w);
            mismatched++;
            return;
        end
        compared++;
        if (w !== expWait) begin
            $display("[TB] FAIL issue_latency: got %0d cycles, expected %0d", w, expWait);
            mismatched++;
        end
        compared++;
        if (pc !== 8'(expIssue) || imem_address !== 8'(expIssue)) begin
            $display("[TB] FAIL issue_pc: pc=%0d addr=%0d, expected %0d", pc, imem_address, expIssue);
            mismatched++;
        end
        compared++;
        if (instr !== mem[expIssue]) begin
            $display("[TB] FAIL issue_instr: got %h, expected %h", instr, mem[expIssue]);
            mismatched++;
        end
        held = instr;
        for (int i = 0; i < readyDelay; i++) begin
            done = 1'($urandom_range(0, 1));
            branch_taken = 1'b1;
            branch_target = 8'($urandom);
            tick();
            compared++;
            if (instr_valid !== 1'b1 || instr !== held) begin
                $display("[TB] FAIL backpressure: valid=%b instr=%h, expected 1 / %h", instr_valid, instr, held);
                mismatched++;
            end
        end
        done = 1'b0;
        branch_taken = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        compared++;
        if (instr_valid !== 1'b0) begin
            $display("[TB] FAIL exec_valid: got %b, expected 0", instr_valid);
            mismatched++;
        end
        if (stopRun) run = 1'b0;
        for (int i = 0; i < doneDelay; i++) begin
            branch_taken = 1'($urandom);
            branch_target = 8'($urandom);
            tick();
        end
        done = 1'b1;
        branch_taken = taken;
        branch_target = target;
        tick();
        done = 1'b0;
        branch_taken = 1'b0;
        expCount++;
        expPc = taken ? int'(target) : (expIssue + 1) % 256;
        if (!run) modelIdle = 1'b1;
        compared++;
        if (retired_count !== 16'(expCount)) begin
            $display("[TB] FAIL retired_count: got %0d, expected %0d", retired_count, 16'(expCount));
            mismatched++;
        end
        compared++;
        if (pc !== 8'(expPc)) begin
            $display("[TB] FAIL next_pc: got %0d, expected %0d", pc, expPc);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        clearMem();
        mem[3] = 32'hDEAD_0003;
        doReset();
        compared++;
        if (pc !== 8'd0 || halted !== 1'b1 || instr_valid !== 1'b0 || retired_count !== 16'd0 || instr !== 32'd0) begin
            $display("[TB] FAIL reset_values: pc=%0d halted=%b valid=%b count=%0d instr=%h, expected 0/1/0/0/0",
                     pc, halted, instr_valid, retired_count, instr);
            mismatched++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if (pc !== 8'd0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
                $display("[TB] FAIL idle_hold: pc=%0d halted=%b valid=%b, expected 0/1/0", pc, halted, instr_valid);
                mismatched++;
            end
        end
    endtask

    task automatic test_sequential();
        clearMem();
        mem[0] = 32'h1111_0000;
        mem[2] = 32'h2222_0002;
        mem[4] = 32'h3333_0004;
        doReset();
        run = 1'b1;
        issueOne(1'b0, 8'd0, 0, 0, 1'b0);
        issueOne(1'b0, 8'd0, 0, 0, 1'b0);
        issueOne(1'b0, 8'd0, 0, 0, 1'b0);
        // Everything past 4 is NOP, so the next issue wraps the scan back to address 0.
        issueOne(1'b0, 8'd0, 0, 0, 1'b1);
        tick();
        compared++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            $display("[TB] FAIL halt_after_done: halted=%b valid=%b, expected 1/0", halted, instr_valid);
            mismatched++;
        end
    endtask

    task automatic test_branch();
        clearMem();
        mem[16] = 32'hB000_0010;
        mem[13] = 32'hB000_000D;
        mem[17] = 32'hB000_0011;
        doReset();
        run = 1'b1;
        issueOne(1'b1, 8'd13, 1, 1, 1'b0);
        issueOne(1'b1, 8'd16, 0, 2, 1'b0);
        issueOne(1'b0, 8'd99, 0, 0, 1'b0);
        issueOne(1'b0, 8'd0, 0, 0, 1'b1);
    endtask

    task automatic test_backpressure_wrap();
        clearMem();
        mem[0] = 32'hC000_0000;
        mem[255] = 32'hC000_00FF;
        doReset();
        run = 1'b1;
        issueOne(1'b1, 8'd255, 5, 0, 1'b0);
        issueOne(1'b0, 8'd7, 2, 1, 1'b0);
        issueOne(1'b0, 8'd0, 0, 0, 1'b1);
    endtask

    task automatic test_halt_reset();
        int w;
        clearMem();
        mem[0] = 32'hD000_0000;
        mem[1] = 32'hD000_0001;
        doReset();
        run = 1'b1;
        issueOne(1'b0, 8'd0, 0, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 8'd1) begin
                $display("[TB] FAIL halt_hold: halted=%b valid=%b pc=%0d, expected 1/0/1", halted, instr_valid, pc);
                mismatched++;
            end
        end
        run = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (!instr_valid && w < 20);
        reset_n = 1'b0;
        #1;
        compared++;
        if (instr_valid !== 1'b0 || retired_count !== 16'd0 || pc !== 8'd0 || halted !== 1'b1) begin
            $display("[TB] FAIL reset_in_issue: valid=%b count=%0d pc=%0d halted=%b, expected 0/0/0/1",
                     instr_valid, retired_count, pc, halted);
            mismatched++;
        end
        tick();
        reset_n = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_random();
        clearMem();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) mem[i] = $urandom | 32'h1;
        end
        mem[$urandom_range(0, 255)] = 32'hA5A5_0001;
        doReset();
        run = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bit stop;
            stop = ($urandom_range(0, 7) == 0);
            issueOne(1'($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), stop);
            if (stop) begin
                tick();
                compared++;
                if (halted !== 1'b1) begin
                    $display("[TB] FAIL random_halt: halted=%b, expected 1", halted);
                    mismatched++;
                end
                run = 1'b1;
            end
        end
        run = 1'b0;
        tick();
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        int validCount;
        int phase;
        clearMem();
        mem[2] = 32'hE000_0002;
        mem[5] = 32'hE000_0005;
        doReset();
        step = 1'b1;
        tick();
        step = 1'b0;
        validCount = 0;
        phase = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            done = 1'b0;
            instr_ready = 1'b0;
            if (instr_valid) begin
                validCount++;
                instr_ready = 1'b1;
                phase = 1;
            end else if (phase == 1) begin
                done = 1'b1;
                phase = 2;
            end
        end
        compared++;
        if (validCount !== 1 || retired_count !== 16'd1 || halted !== 1'b1 || pc !== 8'd3) begin
            $display("[TB] FAIL single_step: valids=%0d count=%0d halted=%b pc=%0d, expected 1/1/1/3",
                     validCount, retired_count, halted, pc);
            mismatched++;
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        validCount = 0;
        phase = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            done = 1'b0;
            instr_ready = 1'b0;
            step = 1'b0;
            if (instr_valid) begin
                validCount++;
                instr_ready = 1'b1;
                phase = 1;
            end else if (phase == 1) begin
                step = 1'b1;
                phase = 2;
            end else if (phase == 2) begin
                done = 1'b1;
                phase = 3;
            end
        end
        compared++;
        if (validCount !== 1 || retired_count !== 16'd2 || halted !== 1'b1 || pc !== 8'd6) begin
            $display("[TB] FAIL step_in_exec: valids=%0d count=%0d halted=%b pc=%0d, expected 1/2/1/6",
                     validCount, retired_count, halted, pc);
            mismatched++;
        end
    endtask
`endif

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure_wrap();
        test_halt_reset();
        test_random();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
